uart_rx_axis_fifo: RTL and testbench

Parametrised UART receiver that deserialises frames from an asynchronous `rx` line and emits them on an AXI4-Stream master port. It buffers received words in an internal FIFO, so downstream back-pressure does not lose data until that FIFO fills. It is the next-generation receive path for the UART/AXIS bridge. Over the earlier receiver it adds a runtime bit-rate divisor, 3-sample majority voting, false-start rejection, framing/parity/break status, and overrun reporting.

---
 rtl/uart_rx_axis_fifo_if.sv | 12 +
 rtl/uart_rx_axis_fifo.sv | 216 +++++++++++++++++++++
 tb/tb_uart_rx_axis_fifo.sv | 272 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_axis_fifo_if.sv
// AXI4-Stream bundle carrying received UART words and their per-word status bits.
interface uart_rx_axis_fifo_if #(
    parameter int unsigned DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tdata;
    logic [2:0]           tuser;
    logic                 tvalid;
    logic                 tready;

    modport master (output tdata, tuser, tvalid, input tready);
    modport slave  (input tdata, tuser, tvalid, output tready);
endinterface

// File: rtl/uart_rx_axis_fifo.sv
// UART receiver with runtime divisor, 3-sample majority voting and error status,
// feeding a first-word-fall-through FIFO that drives an AXI4-Stream master port.
module uart_rx_axis_fifo #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned PARITY     = 0,
    parameter int unsigned STOP_BITS  = 1,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned DIV_WIDTH  = 16
) (
    input  logic                        aclk,
    input  logic                        areset,
    input  logic                        rx,
    input  logic [DIV_WIDTH-1:0]        baud_div,
    uart_rx_axis_fifo_if.master         m_axis,
    output logic                        overrun,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);
    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned WW = DATA_BITS + 3;

    localparam logic [2:0] StIdle     = 3'd0;
    localparam logic [2:0] StStart    = 3'd1;
    localparam logic [2:0] StData     = 3'd2;
    localparam logic [2:0] StParity   = 3'd3;
    localparam logic [2:0] StStop1    = 3'd4;
    localparam logic [2:0] StStop2    = 3'd5;
    localparam logic [2:0] StWaitHigh = 3'd6;

    localparam logic [DIV_WIDTH-1:0] MinDiv  = DIV_WIDTH'(4);
    localparam logic [DIV_WIDTH-1:0] One     = DIV_WIDTH'(1);
    localparam logic [3:0]           LastBit = 4'(DATA_BITS - 1);
    localparam logic                 OddPar  = (PARITY == 1);

    logic rx_meta_q, rx_sync_q, rx_prev_q;

    logic [2:0]           state_q, state_d;
    logic [DIV_WIDTH-1:0] cnt_q, cnt_d;
    logic [DIV_WIDTH-1:0] div_q, div_d;
    logic                 s1_q, s1_d, s2_q, s2_d;
    logic [3:0]           bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 par_err_q, par_err_d;
    logic                 frm_err_q, frm_err_d;
    logic                 seen_one_q, seen_one_d;

    logic [DIV_WIDTH-1:0] mid;
    logic                 at_lo, at_mid, at_dec, at_end;
    logic                 maj, fell, last_stop, brk;
    logic                 wr_en;
    logic [WW-1:0]        wr_word;

    logic [WW-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          overrun_q;
    logic          full, pop, push;

    always_comb begin
        mid       = div_q >> 1;
        at_lo     = (cnt_q == mid - One);
        at_mid    = (cnt_q == mid);
        at_dec    = (cnt_q == mid + One);
        at_end    = (cnt_q == div_q - One);
        maj       = (s1_q & s2_q) | (s1_q & rx_sync_q) | (s2_q & rx_sync_q);
        fell      = rx_prev_q & ~rx_sync_q;
        last_stop = at_dec && (((state_q == StStop1) && (STOP_BITS == 1)) ||
                               (state_q == StStop2));
        brk       = ~(seen_one_q | maj);
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        div_d      = div_q;
        s1_d       = s1_q;
        s2_d       = s2_q;
        bit_idx_d  = bit_idx_q;
        data_d     = data_q;
        par_err_d  = par_err_q;
        frm_err_d  = frm_err_q;
        seen_one_d = seen_one_q;
        wr_en      = 1'b0;
        wr_word    = '0;

        if ((state_q != StIdle) && (state_q != StWaitHigh)) begin
            cnt_d = at_end ? '0 : cnt_q + One;
            if (at_lo)  s1_d = rx_sync_q;
            if (at_mid) s2_d = rx_sync_q;
        end

        case (state_q)
            StIdle: begin
                if (fell) begin
                    state_d    = StStart;
                    cnt_d      = '0;
                    div_d      = (baud_div < MinDiv) ? MinDiv : baud_div;
                    bit_idx_d  = '0;
                    data_d     = '0;
                    par_err_d  = 1'b0;
                    frm_err_d  = 1'b0;
                    seen_one_d = 1'b0;
                end
            end
            StStart: begin
                if (at_dec && maj) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (at_end) begin
                    state_d = StData;
                end
            end
            StData: begin
                if (at_dec) begin
                    data_d     = {maj, data_q[DATA_BITS-1:1]};
                    seen_one_d = seen_one_q | maj;
                end
                if (at_end) begin
                    if (bit_idx_q == LastBit) begin
                        bit_idx_d = '0;
                        state_d   = (PARITY != 0) ? StParity : StStop1;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            StParity: begin
                if (at_dec) begin
                    par_err_d  = (^data_q) ^ maj ^ OddPar;
                    seen_one_d = seen_one_q | maj;
                end
                if (at_end) state_d = StStop1;
            end
            StStop1: begin
                if (at_dec) begin
                    frm_err_d  = frm_err_q | ~maj;
                    seen_one_d = seen_one_q | maj;
                end
                if (at_end) state_d = StStop2;
            end
            StStop2: ;
            StWaitHigh: begin
                if (rx_sync_q) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Commit on the last stop decision; do not wait for the end of the stop bit.
        if (last_stop) begin
            wr_en   = 1'b1;
            wr_word = {brk, frm_err_q | ~maj | brk, par_err_q, data_q};
            state_d = brk ? StWaitHigh : StIdle;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            state_q    <= StIdle;
            cnt_q      <= '0;
            div_q      <= MinDiv;
            s1_q       <= 1'b1;
            s2_q       <= 1'b1;
            bit_idx_q  <= '0;
            data_q     <= '0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            seen_one_q <= 1'b0;
        end else begin
            rx_meta_q  <= rx;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            div_q      <= div_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            bit_idx_q  <= bit_idx_d;
            data_q     <= data_d;
            par_err_q  <= par_err_d;
            frm_err_q  <= frm_err_d;
            seen_one_q <= seen_one_d;
        end
    end

    // A full FIFO still accepts a write when a pop frees a slot in the same cycle.
    assign full = (count_q == CW'(FIFO_DEPTH));
    assign pop  = m_axis.tvalid & m_axis.tready;
    assign push = wr_en & (~full | pop);

    always_ff @(posedge aclk) begin
        if (push) mem_q[wr_ptr_q] <= wr_word;
    end

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_q + AW'(push);
            rd_ptr_q  <= rd_ptr_q + AW'(pop);
            count_q   <= count_q + CW'(push) - CW'(pop);
            overrun_q <= wr_en & full & ~pop;
        end
    end

    assign m_axis.tvalid = (count_q != '0);
    assign {m_axis.tuser, m_axis.tdata} = m_axis.tvalid ? mem_q[rd_ptr_q] : '0;
    assign overrun       = overrun_q;
    assign fifo_count    = count_q;
endmodule

// File: tb/tb_uart_rx_axis_fifo.sv
// Randomised self-checking bench for uart_rx_axis_fifo (8E1, 4-deep FIFO) against a
// frame-level reference model.
module tb_uart_rx_axis_fifo;
    localparam int DATA_BITS  = 8;
    localparam int PARITY     = 2;
    localparam int STOP_BITS  = 1;
    localparam int FIFO_DEPTH = 4;
    localparam int DIV_WIDTH  = 16;
    localparam int FRAME_BITS = 1 + DATA_BITS + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

    logic                 clk = 1'b0;
    logic                 areset;
    logic                 rx;
    logic [DIV_WIDTH-1:0] baud_div;
    logic                 overrun;
    logic [2:0]           fifo_count;

    uart_rx_axis_fifo_if #(.DATA_BITS(DATA_BITS)) axis ();

    uart_rx_axis_fifo #(
        .DATA_BITS (DATA_BITS),
        .PARITY    (PARITY),
        .STOP_BITS (STOP_BITS),
        .FIFO_DEPTH(FIFO_DEPTH),
        .DIV_WIDTH (DIV_WIDTH)
    ) dut (
        .aclk      (clk),
        .areset    (areset),
        .rx        (rx),
        .baud_div  (baud_div),
        .m_axis    (axis),
        .overrun   (overrun),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    logic [10:0] exp_q[$];
    int   n_beats  = 0;
    int   n_extra  = 0;
    int   n_ovr    = 0;
    int   rise_cyc = -1;
    logic vld_prev = 1'b0;

    always @(negedge clk) begin
        if (!areset) begin
            if (overrun) n_ovr <= n_ovr + 1;
            if (axis.tvalid && !vld_prev) rise_cyc <= cyc;
            if (axis.tvalid && axis.tready) begin
                n_beats <= n_beats + 1;
                if (exp_q.size() == 0) n_extra <= n_extra + 1;
                else check_eq("beat", 32'({axis.tuser, axis.tdata}), 32'(exp_q.pop_front()));
            end
        end
        vld_prev <= axis.tvalid;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_bit(input logic b, input int div);
        rx = b;
        tick(div);
    endtask

    task automatic send_frame(input int div, input logic [7:0] d, input logic par,
                              input logic stp);
        send_bit(1'b0, div);
        for (int i = 0; i < DATA_BITS; i++) send_bit(d[i], div);
        if (PARITY != 0) send_bit(par, div);
        for (int i = 0; i < STOP_BITS; i++) send_bit(stp, div);
    endtask

    function automatic logic good_par(input logic [7:0] d);
        return (^d) ^ (PARITY == 1);
    endfunction

    // Expected beat {break, framing, parity, data} for one frame as sent on the line.
    function automatic logic [10:0] exp_word(input logic [7:0] d, input logic par,
                                             input logic stp);
        logic perr, brk;
        perr = (PARITY != 0) && (par != good_par(d));
        brk  = (d == 8'h00) && ((PARITY == 0) || !par) && !stp;
        return {brk, brk | !stp, perr, d};
    endfunction

    task automatic send_exp(input int div_raw, input logic [7:0] d, input logic par,
                            input logic stp);
        baud_div = DIV_WIDTH'(div_raw);
        exp_q.push_back(exp_word(d, par, stp));
        send_frame((div_raw < 4) ? 4 : div_raw, d, par, stp);
    endtask

    task automatic wait_drain(input string tag, input int budget);
        for (int i = 0; i < budget && exp_q.size() != 0; i++) tick(1);
        check_eq(tag, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    int   t0, b0, o0;
    logic done;
    int   div_raw, gap;
    logic [7:0] d;
    logic par, stp;

    initial begin
        areset      = 1'b1;
        rx          = 1'b1;
        baud_div    = 16'd16;
        axis.tready = 1'b1;
        tick(3);
        check_eq("rst_tvalid", 32'(axis.tvalid), 32'd0);
        check_eq("rst_tdata", 32'(axis.tdata), 32'd0);
        check_eq("rst_tuser", 32'(axis.tuser), 32'd0);
        check_eq("rst_overrun", 32'(overrun), 32'd0);
        check_eq("rst_count", 32'(fifo_count), 32'd0);
        areset = 1'b0;
        tick(3);

        // Basic back-to-back frames and first-word latency.
        t0 = cyc;
        send_exp(16, 8'hA5, good_par(8'hA5), 1'b1);
        check_eq("first_valid_cycle", 32'(rise_cyc), 32'(t0 + 3 + (FRAME_BITS - 1) * 16 + 8 + 2));
        send_exp(16, 8'h3C, good_par(8'h3C), 1'b1);
        wait_drain("drain_basic", 200);

        // Parity: 0x07 with parity bit 0 and 1.
        send_exp(16, 8'h07, 1'b0, 1'b1);
        tick(2);
        send_exp(16, 8'h07, 1'b1, 1'b1);
        wait_drain("drain_parity", 200);

        // Three-cycle glitch must be rejected as a false start.
        b0 = n_beats;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(60);
        check_eq("glitch_beats", 32'(n_beats - b0), 32'd0);
        check_eq("glitch_count", 32'(fifo_count), 32'd0);

        // Framing error.
        send_exp(16, 8'h55, good_par(8'h55), 1'b0);
        rx = 1'b1;
        tick(4);
        wait_drain("drain_framing", 200);

        // Break: line low for three frame times, then a normal frame.
        b0 = n_beats;
        exp_q.push_back(exp_word(8'h00, 1'b0, 1'b0));
        rx = 1'b0;
        tick(3 * FRAME_BITS * 16);
        rx = 1'b1;
        tick(6);
        check_eq("break_beats", 32'(n_beats - b0), 32'd1);
        send_exp(16, 8'h81, good_par(8'h81), 1'b1);
        wait_drain("drain_break", 200);

        // Overflow: only the first FIFO_DEPTH frames survive with tready low.
        axis.tready = 1'b0;
        o0 = n_ovr;
        baud_div = 16'd8;
        for (int v = 1; v <= 5; v++) begin
            if (v <= FIFO_DEPTH) exp_q.push_back(exp_word(8'(v), good_par(8'(v)), 1'b1));
            send_frame(8, 8'(v), good_par(8'(v)), 1'b1);
            tick(3);
        end
        tick(5);
        check_eq("ovf_count", 32'(fifo_count), 32'(FIFO_DEPTH));
        check_eq("ovf_pulses", 32'(n_ovr - o0), 32'd1);
        check_eq("ovf_tvalid", 32'(axis.tvalid), 32'd1);
        check_eq("ovf_head", 32'(axis.tdata), 32'd1);
        axis.tready = 1'b1;
        wait_drain("drain_ovf", 100);

        // Reset mid-DATA with two words buffered.
        axis.tready = 1'b0;
        baud_div = 16'd16;
        send_frame(16, 8'h11, good_par(8'h11), 1'b1);
        send_frame(16, 8'h22, good_par(8'h22), 1'b1);
        tick(4);
        check_eq("pre_rst_count", 32'(fifo_count), 32'd2);
        send_bit(1'b0, 16);
        for (int i = 0; i < 4; i++) send_bit(1'(i), 16);
        areset = 1'b1;
        #1;
        check_eq("mid_rst_tvalid", 32'(axis.tvalid), 32'd0);
        check_eq("mid_rst_tdata", 32'(axis.tdata), 32'd0);
        check_eq("mid_rst_tuser", 32'(axis.tuser), 32'd0);
        check_eq("mid_rst_overrun", 32'(overrun), 32'd0);
        check_eq("mid_rst_count", 32'(fifo_count), 32'd0);
        rx = 1'b1;
        tick(3);
        areset = 1'b0;
        axis.tready = 1'b1;
        b0 = n_beats;
        tick(300);
        check_eq("post_rst_beats", 32'(n_beats - b0), 32'd0);

        // Divisor change mid-frame applies only to the next frame.
        exp_q.push_back(exp_word(8'h6B, good_par(8'h6B), 1'b1));
        fork
            send_frame(16, 8'h6B, good_par(8'h6B), 1'b1);
            begin
                tick(60);
                baud_div = 16'd8;
            end
        join
        exp_q.push_back(exp_word(8'hC4, good_par(8'hC4), 1'b1));
        send_frame(8, 8'hC4, good_par(8'hC4), 1'b1);
        wait_drain("drain_divchg", 200);

        // Randomised frames, divisors (including clamped ones) and back-pressure.
        done = 1'b0;
        fork
            begin
                for (int f = 0; f < 30; f++) begin
                    div_raw = $urandom_range(0, 20);
                    d       = 8'($urandom);
                    par     = ($urandom_range(0, 7) == 0) ? ~good_par(d) : good_par(d);
                    stp     = ($urandom_range(0, 5) != 0);
                    if ($urandom_range(0, 9) == 0) begin
                        d   = 8'h00;
                        par = 1'b0;
                        stp = 1'b0;
                    end
                    send_exp(div_raw, d, par, stp);
                    gap = stp ? $urandom_range(0, 3) : $urandom_range(3, 6);
                    rx  = 1'b1;
                    tick(gap);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    axis.tready = 1'($urandom_range(0, 1));
                    tick(1);
                end
            end
        join
        axis.tready = 1'b1;
        wait_drain("drain_random", 200);
        check_eq("extra_beats", 32'(n_extra), 32'd0);
        check_eq("final_count", 32'(fifo_count), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
